// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter: round-robin sharing of one AHB manager request front-end
// among NUM_REQ requesters. Captures the winner's command, holds it on req_*
// until req_ready, then keeps ownership until every read beat has returned.
// Optional read-response watchdog is compiled in with `define ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no owner; arbitrate among pending requesters
// ARB_ISSUE | captured command driven on req_*, waiting for req_ready
// ARB_WAIT  | read accepted, collecting the remaining response beats
module ahb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [NUM_REQ-1:0]            m_req_read,
    input  logic [NUM_REQ-1:0]            m_req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] m_req_wdata,
    input  logic [NUM_REQ*3-1:0]          m_req_size,
    input  logic [NUM_REQ*3-1:0]          m_req_burst,
    output logic [NUM_REQ-1:0]            m_grant,
    output logic [NUM_REQ-1:0]            m_resp_valid,
    output logic [DATA_WIDTH-1:0]         m_resp_rdata,
    output logic [NUM_REQ-1:0]            m_resp_err,
    output logic                          req_read,
    output logic                          req_write,
    output logic [ADDR_WIDTH-1:0]         req_addr,
    output logic [DATA_WIDTH-1:0]         req_wdata,
    output logic [2:0]                    req_size,
    output logic [2:0]                    req_burst,
    input  logic                          req_ready,
    input  logic                          resp_read,
    input  logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          busy
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    arb_state_t         state, state_nxt;
    logic [OW-1:0]      owner, last_grant, pick_idx;
    logic               pick_valid;
    logic               cmd_read, cmd_write;
    logic [4:0]         beats;
    logic [NUM_REQ-1:0] pending;
    logic               last_beat, timeout_hit;

    function automatic logic [4:0] burst_beats(input logic [2:0] code);
        case (code)
            3'b001:  return 5'd4;
            3'b010:  return 5'd8;
            3'b011:  return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

    assign pending   = m_req_read | m_req_write;
    assign last_beat = (state == ARB_WAIT) && resp_read && (beats == 5'd1);

    // Round-robin pick: first pending index above last_grant, wrapping
    always_comb begin
        logic [OW:0] idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_grant} + (OW+1)'(k);
            if (idx >= (OW+1)'(NUM_REQ))
                idx = idx - (OW+1)'(NUM_REQ);
            if (!pick_valid && pending[idx[OW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = idx[OW-1:0];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wait_cnt;

    // Watchdog: idle outside ARB_WAIT, restarts on every beat
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            wait_cnt <= '0;
        else if (state != ARB_WAIT || resp_read)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout_hit = (state == ARB_WAIT) && !resp_read &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_valid) state_nxt = ARB_ISSUE;
            ARB_ISSUE: if (req_ready)  state_nxt = cmd_write ? ARB_IDLE : ARB_WAIT;
            ARB_WAIT:  if (last_beat || timeout_hit) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // Command capture, ownership and beat counting
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner      <= '0;
            last_grant <= OW'(NUM_REQ - 1);
            cmd_read   <= 1'b0;
            cmd_write  <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_size   <= '0;
            req_burst  <= '0;
            beats      <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner      <= pick_idx;
                        last_grant <= pick_idx;
                        // write wins when both strobes are high
                        cmd_write  <= m_req_write[pick_idx];
                        cmd_read   <= m_req_read[pick_idx] & ~m_req_write[pick_idx];
                        req_addr   <= m_req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        req_wdata  <= m_req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        req_size   <= m_req_size[int'(pick_idx)*3 +: 3];
                        req_burst  <= m_req_burst[int'(pick_idx)*3 +: 3];
                    end
                end
                ARB_ISSUE: begin
                    if (req_ready && !cmd_write)
                        beats <= burst_beats(req_burst);
                end
                ARB_WAIT: begin
                    if (timeout_hit)
                        beats <= '0;
                    else if (resp_read)
                        beats <= beats - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: grant and response routing are combinational to the owner
    always_comb begin
        m_grant      = '0;
        m_resp_valid = '0;
        m_resp_err   = '0;
        m_resp_rdata = '0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        busy         = (state != ARB_IDLE);
        case (state)
            ARB_ISSUE: begin
                req_read  = cmd_read;
                req_write = cmd_write;
                if (req_ready)
                    m_grant[owner] = 1'b1;
            end
            ARB_WAIT: begin
                if (resp_read) begin
                    m_resp_valid[owner] = 1'b1;
                    m_resp_rdata        = resp_rdata;
                end
                if (timeout_hit)
                    m_resp_err[owner] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
